// File: rtl/multi_field_line_decoder.sv
// multi_field_line_decoder: parses an ASCII byte stream into tagged lines of decimal fields.
// Optional macro MULTI_FIELD_SIGNED_EN: fields become two's-complement with a leading '-'.
module multi_field_line_decoder #(
   parameter int FIELD_BITS = 32,
   parameter int MAX_FIELDS = 4,
   parameter int COUNT_BITS = $clog2(MAX_FIELDS + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             inbound_valid,
   input  logic [7:0]                       inbound_byte,
   output logic                             end_of_file,
   output logic                             line_valid,
   output logic [7:0]                       line_tag,
   output logic [COUNT_BITS-1:0]            line_field_count,
   output logic [MAX_FIELDS*FIELD_BITS-1:0] line_fields,
   output logic                             line_overflow,
   output logic                             line_error
);

`ifdef MULTI_FIELD_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   localparam int AW = FIELD_BITS + 4;
   localparam int LW = MAX_FIELDS * FIELD_BITS;
   localparam logic [AW-1:0] U_LIM = {4'b0, {FIELD_BITS{1'b1}}};
   localparam logic [AW-1:0] P_LIM = {5'b0, {(FIELD_BITS-1){1'b1}}};
   localparam logic [AW-1:0] N_LIM = {4'b0, 1'b1, {(FIELD_BITS-1){1'b0}}};
   localparam logic [AW-1:0] TEN = AW'(10);
   localparam logic [COUNT_BITS-1:0] FULL = COUNT_BITS'(MAX_FIELDS);
   localparam logic [COUNT_BITS-1:0] C_ONE = COUNT_BITS'(1);
   localparam logic [FIELD_BITS-1:0] F_ONE = FIELD_BITS'(1);

   typedef enum logic [1:0] {
      LINE_START,
      IN_SEP,
      IN_NUMBER,
      EOF
   } state_t;

   state_t                state, state_n;
   logic [FIELD_BITS-1:0] acc, acc_n;
   logic [7:0]            tag, tag_n;
   logic [COUNT_BITS-1:0] cnt, cnt_n;
   logic [LW-1:0]         flds, flds_n;
   logic                  ovf, ovf_n;
   logic                  err, err_n;
   logic                  neg, neg_n;
   logic                  pend, pend_n;

   logic                  emit, eof_set;
   logic [7:0]            rec_tag;
   logic [COUNT_BITS-1:0] rec_cnt;
   logic [LW-1:0]         rec_flds;
   logic                  rec_ovf, rec_err;
   logic [AW-1:0]         nxt_val, lim;

   logic is_dig, is_tag, is_sep, is_minus, is_cr, is_lf, is_nul, in_num;
   logic [AW-1:0]         dval;
   logic [FIELD_BITS-1:0] cval;

   assign is_dig   = inbound_byte >= 8'h30 && inbound_byte <= 8'h39;
   assign is_tag   = inbound_byte >= 8'h41 && inbound_byte <= 8'h5A;
   assign is_minus = inbound_byte == 8'h2D;
   assign is_sep   = inbound_byte == 8'h2C || inbound_byte == 8'h20 || is_minus;
   assign is_cr    = inbound_byte == 8'h0D;
   assign is_lf    = inbound_byte == 8'h0A;
   assign is_nul   = inbound_byte == 8'h00;
   assign in_num   = state == IN_NUMBER;
   assign dval     = {{(AW-4){1'b0}}, inbound_byte[3:0]};
   assign cval     = (SIGNED_EN && neg) ? (~acc + F_ONE) : acc;

   // Per-byte parse: commit pending number, classify byte, build record on LF/NUL
   always_comb begin
      state_n  = state;
      acc_n    = acc;
      tag_n    = tag;
      cnt_n    = cnt;
      flds_n   = flds;
      ovf_n    = ovf;
      err_n    = err;
      neg_n    = neg;
      pend_n   = pend;
      emit     = 1'b0;
      eof_set  = 1'b0;
      nxt_val  = '0;
      lim      = '0;
      rec_tag  = '0;
      rec_cnt  = '0;
      rec_flds = '0;
      rec_ovf  = 1'b0;
      rec_err  = 1'b0;
      if (inbound_valid && state != EOF && !is_cr) begin
         pend_n = 1'b0;
         if (in_num && !is_dig) begin
            if (cnt == FULL) begin
               err_n = 1'b1;
            end else begin
               flds_n[int'(cnt)*FIELD_BITS +: FIELD_BITS] = cval;
               cnt_n = cnt + C_ONE;
            end
            state_n = IN_SEP;
         end
         unique case (1'b1)
            is_dig: begin
               nxt_val = in_num ? ({4'b0, acc} * TEN + dval) : dval;
               neg_n   = in_num ? neg : (SIGNED_EN && pend);
               lim     = !SIGNED_EN ? U_LIM : (neg_n ? N_LIM : P_LIM);
               if (nxt_val > lim) begin
                  acc_n = lim[FIELD_BITS-1:0];
                  ovf_n = 1'b1;
               end else begin
                  acc_n = nxt_val[FIELD_BITS-1:0];
               end
               state_n = IN_NUMBER;
            end
            is_lf, is_nul: begin
               emit     = is_lf || state != LINE_START;
               eof_set  = is_nul;
               rec_tag  = tag_n;
               rec_cnt  = cnt_n;
               rec_flds = flds_n;
               rec_ovf  = ovf_n;
               rec_err  = err_n;
               acc_n    = '0;
               tag_n    = '0;
               cnt_n    = '0;
               flds_n   = '0;
               ovf_n    = 1'b0;
               err_n    = 1'b0;
               neg_n    = 1'b0;
               state_n  = is_nul ? EOF : LINE_START;
            end
            is_tag: begin
               if (state == LINE_START) tag_n = inbound_byte;
               else err_n = 1'b1;
               state_n = IN_SEP;
            end
            is_sep: begin
               pend_n  = SIGNED_EN && is_minus && !in_num;
               state_n = IN_SEP;
            end
            default: begin
               err_n   = 1'b1;
               state_n = IN_SEP;
            end
         endcase
      end
   end

   // Working registers of the line being parsed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LINE_START;
         acc   <= '0;
         tag   <= '0;
         cnt   <= '0;
         flds  <= '0;
         ovf   <= 1'b0;
         err   <= 1'b0;
         neg   <= 1'b0;
         pend  <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         tag   <= tag_n;
         cnt   <= cnt_n;
         flds  <= flds_n;
         ovf   <= ovf_n;
         err   <= err_n;
         neg   <= neg_n;
         pend  <= pend_n;
      end
   end

   // Record outputs: pulse valid, hold record until next line, sticky end_of_file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         end_of_file      <= 1'b0;
         line_valid       <= 1'b0;
         line_tag         <= '0;
         line_field_count <= '0;
         line_fields      <= '0;
         line_overflow    <= 1'b0;
         line_error       <= 1'b0;
      end else begin
         line_valid <= emit;
         if (eof_set) end_of_file <= 1'b1;
         if (emit) begin
            line_tag         <= rec_tag;
            line_field_count <= rec_cnt;
            line_fields      <= rec_flds;
            line_overflow    <= rec_ovf;
            line_error       <= rec_err;
         end
      end
   end

endmodule

// File: tb/tb_multi_field_line_decoder.sv
// tb_multi_field_line_decoder: table vectors, hand sequences and random lines
// checked against a reference parser model through an expected-record queue.
module tb_multi_field_line_decoder;

   localparam int FB = 32;
   localparam int MF = 4;
   localparam int CB = $clog2(MF + 1);

`ifdef MULTI_FIELD_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              inbound_valid;
   logic [7:0]        inbound_byte;
   logic              end_of_file;
   logic              line_valid;
   logic [7:0]        line_tag;
   logic [CB-1:0]     line_field_count;
   logic [MF*FB-1:0]  line_fields;
   logic              line_overflow;
   logic              line_error;

   multi_field_line_decoder #(.FIELD_BITS(FB), .MAX_FIELDS(MF)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .inbound_valid    (inbound_valid),
      .inbound_byte     (inbound_byte),
      .end_of_file      (end_of_file),
      .line_valid       (line_valid),
      .line_tag         (line_tag),
      .line_field_count (line_field_count),
      .line_fields      (line_fields),
      .line_overflow    (line_overflow),
      .line_error       (line_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]       tag;
      int               cnt;
      logic [MF*FB-1:0] flds;
      bit               ovf;
      bit               err;
   } rec_t;

   typedef struct {
      string      txt;
      logic [7:0] tag;
      int         cnt;
      logic [31:0] f0, f1, f2, f3;
      bit         ovf;
      bit         err;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   rec_t exp_q[$];
   rec_t got_e;
   vec_t vt[$];

   // reference parser state
   bit         m_started, m_innum, m_neg, m_pend, m_ovf, m_err, m_eof;
   longint     m_val;
   longint     m_f[MF];
   int         m_cnt;
   logic [7:0] m_tag;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Scoreboard: every line_valid must match the oldest expected record
   always @(negedge clk) begin
      if (rst_n && line_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_line_valid tag=%h cnt=%0d f=%h",
                     line_tag, line_field_count, line_fields);
         end else begin
            got_e = exp_q.pop_front();
            if (line_tag !== got_e.tag || line_field_count !== CB'(got_e.cnt) ||
                line_fields !== got_e.flds || line_overflow !== got_e.ovf ||
                line_error !== got_e.err) begin
               failures++;
               $display("FAIL record got tag=%h cnt=%0d f=%h ovf=%b err=%b expected tag=%h cnt=%0d f=%h ovf=%b err=%b",
                        line_tag, line_field_count, line_fields, line_overflow, line_error,
                        got_e.tag, got_e.cnt, got_e.flds, got_e.ovf, got_e.err);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(string t, logic [7:0] tg, int c, logic [31:0] a, logic [31:0] b,
                               logic [31:0] d, logic [31:0] e, bit o, bit r);
      vec_t v;
      v.txt = t; v.tag = tg; v.cnt = c;
      v.f0 = a; v.f1 = b; v.f2 = d; v.f3 = e;
      v.ovf = o; v.err = r;
      return v;
   endfunction

   task automatic model_clear();
      m_started = 0; m_innum = 0; m_neg = 0; m_pend = 0;
      m_ovf = 0; m_err = 0; m_val = 0; m_cnt = 0; m_tag = 8'h00;
      for (int i = 0; i < MF; i++) m_f[i] = 0;
   endtask

   task automatic model_emit();
      rec_t r;
      r.tag = m_tag; r.cnt = m_cnt; r.flds = '0;
      r.ovf = m_ovf; r.err = m_err;
      for (int i = 0; i < m_cnt; i++) r.flds[i*FB +: FB] = m_f[i][31:0];
      exp_q.push_back(r);
   endtask

   task automatic model_byte(input logic [7:0] b);
      longint lim;
      bit was_num, dig;
      if (m_eof || b == 8'h0D) return;
      dig = b >= "0" && b <= "9";
      was_num = m_innum;
      if (m_innum && !dig) begin
         if (m_cnt == MF) m_err = 1;
         else begin
            m_f[m_cnt] = m_neg ? -m_val : m_val;
            m_cnt++;
         end
         m_innum = 0;
      end
      if (dig) begin
         if (!m_innum) begin
            m_neg = SGN && m_pend;
            m_val = 0;
            m_innum = 1;
         end
         m_val = m_val * 10 + longint'(b - 8'h30);
         lim = !SGN ? 64'hFFFF_FFFF : (m_neg ? 64'h8000_0000 : 64'h7FFF_FFFF);
         if (m_val > lim) begin
            m_val = lim;
            m_ovf = 1;
         end
         m_pend = 0;
         m_started = 1;
      end else if (b == 8'h0A || b == 8'h00) begin
         if (b == 8'h0A || m_started) model_emit();
         if (b == 8'h00) m_eof = 1;
         model_clear();
      end else begin
         if (b >= "A" && b <= "Z") begin
            if (!m_started) m_tag = b;
            else m_err = 1;
         end else if (!(b == "," || b == " " || b == "-")) begin
            m_err = 1;
         end
         m_pend = SGN && b == "-" && !was_num;
         m_started = 1;
      end
   endtask

   task automatic put(input logic [7:0] b);
      @(negedge clk);
      inbound_valid = 1'b1;
      inbound_byte = b;
      @(posedge clk);
      #1 inbound_valid = 1'b0;
   endtask

   task automatic put_m(input logic [7:0] b);
      model_byte(b);
      put(b);
   endtask

   task automatic put_str(input string s);
      for (int i = 0; i < s.len(); i++) put_m(s[i]);
   endtask

   task automatic idle();
      @(negedge clk);
      inbound_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 6 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s pending=%0d expected=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic logic [7:0] rnd_char();
      int k;
      logic [7:0] ill [3];
      ill[0] = "x"; ill[1] = "?"; ill[2] = ".";
      k = $urandom_range(0, 99);
      if (k < 52) return 8'h30 + 8'($urandom_range(0, 9));
      if (k < 62) return ",";
      if (k < 68) return " ";
      if (k < 76) return "-";
      if (k < 84) return 8'h41 + 8'($urandom_range(0, 25));
      if (k < 89) return 8'h0D;
      if (k < 93) return ill[$urandom_range(0, 2)];
      return "9";
   endfunction

   initial begin
      rec_t r;
      rst_n = 1'b0;
      inbound_valid = 1'b0;
      inbound_byte = 8'h00;
      model_clear();
      m_eof = 0;
      repeat (3) @(negedge clk);
      chk("reset_fields", line_fields, '0);
      chk("reset_misc", {end_of_file, line_valid, line_tag, line_field_count,
                         line_overflow, line_error}, '0);
      rst_n = 1'b1;

      vt.push_back(mk("R12,7\n", 8'h52, 2, 12, 7, 0, 0, 0, 0));
      vt.push_back(mk("11-22 33\n", 8'h00, 3, 11, 22, 33, 0, 0, 0));
      vt.push_back(mk("\n", 8'h00, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk("5\n", 8'h00, 1, 5, 0, 0, 0, 0, 0));
      vt.push_back(mk("1,2,3,4,5\n", 8'h00, 4, 1, 2, 3, 4, 0, 1));
      vt.push_back(mk("7x\n", 8'h00, 1, 7, 0, 0, 0, 0, 1));
      vt.push_back(mk("A1B2\n", 8'h41, 2, 1, 2, 0, 0, 0, 1));
      vt.push_back(mk(",,3,\n", 8'h00, 1, 3, 0, 0, 0, 0, 0));
      vt.push_back(mk("12\r34\n", 8'h00, 1, 1234, 0, 0, 0, 0, 0));
      vt.push_back(mk(" Q5\n", 8'h00, 1, 5, 0, 0, 0, 0, 1));
      vt.push_back(mk("Z0007\n", 8'h5A, 1, 7, 0, 0, 0, 0, 0));
`ifdef MULTI_FIELD_SIGNED_EN
      vt.push_back(mk("2147483647\n", 8'h00, 1, 32'h7FFF_FFFF, 0, 0, 0, 0, 0));
      vt.push_back(mk("2147483648\n", 8'h00, 1, 32'h7FFF_FFFF, 0, 0, 0, 1, 0));
      vt.push_back(mk("-2147483648\n", 8'h00, 1, 32'h8000_0000, 0, 0, 0, 0, 0));
      vt.push_back(mk("-99999999999\n", 8'h00, 1, 32'h8000_0000, 0, 0, 0, 1, 0));
      vt.push_back(mk("-5,3\n", 8'h00, 2, 32'hFFFF_FFFB, 3, 0, 0, 0, 0));
      vt.push_back(mk("3--4\n", 8'h00, 2, 3, 32'hFFFF_FFFC, 0, 0, 0, 0));
`else
      vt.push_back(mk("4294967295\n", 8'h00, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      vt.push_back(mk("4294967296\n", 8'h00, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 0));
      vt.push_back(mk("5,99999999999999\n", 8'h00, 2, 5, 32'hFFFF_FFFF, 0, 0, 1, 0));
      vt.push_back(mk("3--4\n", 8'h00, 2, 3, 4, 0, 0, 0, 0));
`endif

      foreach (vt[k]) begin
         r.tag = vt[k].tag; r.cnt = vt[k].cnt;
         r.flds = {vt[k].f3, vt[k].f2, vt[k].f1, vt[k].f0};
         r.ovf = vt[k].ovf; r.err = vt[k].err;
         exp_q.push_back(r);
         for (int i = 0; i < vt[k].txt.len(); i++) put(vt[k].txt[i]);
         @(negedge clk);
         chk($sformatf("latency_v%0d", k), line_valid, 1);
         drain($sformatf("drain_v%0d", k));
      end

      model_clear();
      put_str("\n\n\n");
      put_m(8'h0A);
      chk("b2b_lf_a", line_valid, 1);
      put_m(8'h0A);
      chk("b2b_lf_b", line_valid, 1);
      drain("b2b_lf");

      for (int n = 0; n < 80; n++) begin
         int len;
         len = $urandom_range(0, 12);
         if ($urandom_range(0, 7) == 0)
            for (int i = 0; i < 11; i++) put_m("9");
         for (int i = 0; i < len; i++) begin
            put_m(rnd_char());
            if ($urandom_range(0, 3) == 0) idle();
         end
         put_m(8'h0A);
      end
      drain("random");

      put_str("L3\r\n");
      put_str("9");
      chk("eof_before_nul", end_of_file, 0);
      put_m(8'h00);
      @(negedge clk);
      chk("eof_flush_valid", line_valid, 1);
      chk("eof_rise", end_of_file, 1);
      drain("eof_flush");
      put_str("5\n");
      put_str("R8\n");
      repeat (3) @(negedge clk);
      chk("eof_held", end_of_file, 1);
      chk("eof_no_valid", line_valid, 0);

      put_str("R45");
      rst_n = 1'b0;
      #2;
      chk("midreset_fields", line_fields, '0);
      chk("midreset_misc", {end_of_file, line_valid, line_tag, line_field_count,
                            line_overflow, line_error}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      m_eof = 0;
      exp_q.delete();
      put_str("L1\n");
      @(negedge clk);
      chk("after_reset_tag", line_tag, 8'h4C);
      chk("after_reset_f0", line_fields[FB-1:0], 1);
      drain("after_reset");

      put_m(8'h00);
      repeat (2) @(negedge clk);
      chk("nul_empty_eof", end_of_file, 1);
      chk("nul_empty_no_valid", line_valid, 0);
      drain("nul_empty");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_field_line_decoder.md
Name: multi_field_line_decoder

Overview:
- Generalised successor to the single-field click decoder. Parses an ASCII byte stream into lines, each with an optional upper-case tag letter and up to MAX_FIELDS unsigned decimal fields separated by ',', ' ' or '-'.
- Sits between the byte-stream receiver and the puzzle solver cores.
- Emits one registered line record per LF. Saturates oversized numbers and flags malformed input instead of silently corrupting results.

Parameters:
- FIELD_BITS, 32: width of each decoded field.
- MAX_FIELDS, 4: number of field slots per line (>=1).
- COUNT_BITS, $clog2(MAX_FIELDS+1): width of line_field_count (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inbound_valid  in  1  byte strobe, no backpressure
- inbound_byte  in  8  ASCII byte
- end_of_file  out  1  set on NUL, held until reset
- line_valid  out  1  one-cycle pulse per completed line
- line_tag  out  8  tag letter of the line, 8'h00 if none
- line_field_count  out  COUNT_BITS  fields stored (0..MAX_FIELDS)
- line_fields  out  MAX_FIELDS*FIELD_BITS  field i at bits [i*FIELD_BITS +: FIELD_BITS]; unused slots are zero
- line_overflow  out  1  any field saturated in this line
- line_error  out  1  illegal character or excess fields in this line

Behaviour:
- Reset (async assert, sync release): all outputs 0, working registers cleared, FSM in LINE_START.
- FSM states:
  - LINE_START: no byte of the current line consumed yet.
  - IN_SEP: between fields.
  - IN_NUMBER: accumulating digits.
  - EOF: terminal.
- Bytes are consumed only when inbound_valid=1. Character classes: digit 0x30-0x39; tag 0x41-0x5A; separators ',' ' ' '-'; CR 0x0D; LF 0x0A; NUL 0x00; everything else is illegal.
- Tag handling:
  - In LINE_START, a tag letter is latched into the working tag and the FSM goes to IN_SEP.
  - A tag letter in any other state sets the working error flag and acts as a separator.
- Digits:
  - Entering IN_NUMBER loads acc = digit.
  - While in IN_NUMBER, acc = acc*10 + digit, computed at FIELD_BITS+4 bits.
  - If the result exceeds 2^FIELD_BITS-1, acc saturates to all-ones and the working overflow flag is set; acc stays saturated for the remaining digits.
- Field commit:
  - In IN_NUMBER, any non-digit byte (separator, illegal, LF, NUL) commits acc to slot [count] and increments count.
  - If count already equals MAX_FIELDS, the value is dropped and the working error flag is set.
- CR is ignored in every state and does not end a number.
- LF:
  - Commits any pending number.
  - Next cycle: line_valid=1, and line_tag/line_field_count/line_fields/line_overflow/line_error take the working values.
  - Working registers clear and the FSM returns to LINE_START.
  - An empty line (LF in LINE_START) still emits a record with count 0.
- Record outputs hold their values until the next line_valid. Latency from LF to line_valid is exactly 1 cycle.
- NUL:
  - Commits any pending number.
  - If the line is non-empty (FSM not in LINE_START), flushes the record with line_valid in the same cycle that end_of_file rises.
  - FSM enters EOF. In EOF all bytes are ignored, line_valid is never asserted again, and end_of_file stays 1 until rst_n is asserted.
- Reset mid-line discards the partial line; no line_valid is produced for it.
- Back-to-back LF bytes produce consecutive line_valid pulses, each with count 0.

Optional Feature:
- Macro: MULTI_FIELD_SIGNED_EN.
- When defined, fields are two's-complement signed:
  - A '-' in LINE_START or IN_SEP that is directly followed by a digit marks the next field negative.
  - Saturation limits are 2^(FIELD_BITS-1)-1 for positive fields and -2^(FIELD_BITS-1) for negative fields; either limit sets line_overflow.
  - '-' inside IN_NUMBER still acts as a separator.
- When not defined, '-' is a plain separator and fields are unsigned.

Test Plan:
- "R12,7\n" -> line_valid 1 cycle after LF; tag 8'h52, count 2, fields {0,0,7,12}, overflow 0, error 0.
- "11-22 33\n\n" with MAX_FIELDS=4 -> first record count 3, fields 11/22/33, tag 0; second record count 0, all fields 0.
- FIELD_BITS=8, "300\n" -> field0 8'hFF, overflow 1; next line "5\n" -> field0 5, overflow 0.
- "1,2,3,4,5\n" with MAX_FIELDS=4 -> count 4, fields 1..4, error 1; "7x\n" -> field0 7, error 1.
- "L3\r\n" then "9" then NUL -> record L/3, then a record with field0 9 coincident with end_of_file rise; later "5\n" produces no line_valid.
- Assert rst_n low after "R45" -> all outputs 0; then "L1\n" -> tag 8'h4C, field0 1. With MULTI_FIELD_SIGNED_EN, "-5,3\n" -> field0 = -5, field1 = 3.
